// File: rtl/mas_alu_exec.sv
// Multi-cycle ADD/SUB/MUL/MAC execution datapath started by the rising edge of the ALU FSM strobe.
// Optional: define MAS_ALU_EXEC_EARLY_TERM_EN to end MUL/MAC as soon as the multiplier is exhausted.
module mas_alu_exec #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mas_alu_fsm_oper,
    input  logic [1:0]         mas_alu_op,
    input  logic [WIDTH-1:0]   mas_alu_a,
    input  logic [WIDTH-1:0]   mas_alu_b,
    input  logic [WIDTH-1:0]   mas_alu_c,
    output logic               mas_alu_ready,
    output logic               mas_alu_busy,
    output logic [2*WIDTH-1:0] mas_alu_result,
    output logic               mas_alu_zero,
    output logic               mas_alu_neg
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state, state_n;
    logic              oper_q;
    logic              armed;
    logic [1:0]        op_r, op_n;
    logic [RW-1:0]     mcand, mcand_n;
    logic [WIDTH-1:0]  mplier, mplier_n;
    logic [RW-1:0]     acc, acc_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [RW-1:0]     result_n;
    logic              zero_n;
    logic              neg_n;

    logic              start_c;
    logic              last_c;
    logic [RW-1:0]     acc_step_c;
    logic [WIDTH-1:0]  opa_c;

    // A strobe already high out of reset must be seen low once before an edge counts.
    assign start_c = mas_alu_fsm_oper & ~oper_q & armed;

    // Low half of the multiplicand still holds operand A for ADD/SUB.
    assign opa_c = mcand[WIDTH-1:0];

    assign acc_step_c = mplier[0] ? (acc + mcand) : acc;

    // Next-state and datapath update.
    always_comb begin
        state_n  = state;
        op_n     = op_r;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        cnt_n    = cnt;
        result_n = mas_alu_result;
        zero_n   = mas_alu_zero;
        neg_n    = mas_alu_neg;
        last_c   = 1'b0;

        case (state)
            IDLE: begin
                if (start_c) begin
                    op_n     = mas_alu_op;
                    mcand_n  = RW'(mas_alu_a);
                    mplier_n = mas_alu_b;
                    acc_n    = (mas_alu_op == OP_MAC) ? RW'(mas_alu_c) : '0;
                    cnt_n    = mas_alu_op[1] ? CW'(WIDTH) : CW'(1);
                    state_n  = CALC;
                end
            end

            CALC: begin
                if (!mas_alu_fsm_oper) begin
                    state_n = IDLE;
                end else begin
                    acc_n    = acc_step_c;
                    mcand_n  = mcand << 1;
                    mplier_n = mplier >> 1;
                    cnt_n    = cnt - CW'(1);
                    last_c   = (cnt == CW'(1)) || !op_r[1];
`ifdef MAS_ALU_EXEC_EARLY_TERM_EN
                    if (op_r[1] && (mplier_n == '0)) begin
                        last_c = 1'b1;
                    end
`endif
                    if (last_c) begin
                        state_n = DONE;
                        case (op_r)
                            OP_ADD: begin
                                result_n = RW'(opa_c) + RW'(mplier);
                                neg_n    = 1'b0;
                            end
                            OP_SUB: begin
                                result_n = RW'(opa_c) - RW'(mplier);
                                neg_n    = (opa_c < mplier);
                            end
                            OP_MUL, OP_MAC: begin
                                result_n = acc_step_c;
                                neg_n    = 1'b0;
                            end
                            default: begin
                                result_n = '0;
                                neg_n    = 1'b0;
                            end
                        endcase
                        zero_n = (result_n == '0);
                    end
                end
            end

            DONE: begin
                if (!mas_alu_fsm_oper) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            oper_q         <= 1'b0;
            armed          <= 1'b0;
            op_r           <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
            mas_alu_result <= '0;
            mas_alu_zero   <= 1'b0;
            mas_alu_neg    <= 1'b0;
            mas_alu_ready  <= 1'b0;
            mas_alu_busy   <= 1'b0;
        end else begin
            state          <= state_n;
            oper_q         <= mas_alu_fsm_oper;
            armed          <= armed | ~mas_alu_fsm_oper;
            op_r           <= op_n;
            mcand          <= mcand_n;
            mplier         <= mplier_n;
            acc            <= acc_n;
            cnt            <= cnt_n;
            mas_alu_result <= result_n;
            mas_alu_zero   <= zero_n;
            mas_alu_neg    <= neg_n;
            mas_alu_ready  <= (state_n == DONE);
            mas_alu_busy   <= (state_n == CALC);
        end
    end

endmodule

// File: tb/tb_mas_alu_exec.sv
// Randomized self-checking bench for mas_alu_exec (WIDTH=8) against an arithmetic reference model.
module tb_mas_alu_exec;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic           oper;
    logic [1:0]     op;
    logic [W-1:0]   a, b, c;
    logic           ready, busy, zero, neg;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_result;
    logic           last_zero, last_neg;

    mas_alu_exec #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mas_alu_fsm_oper (oper),
        .mas_alu_op       (op),
        .mas_alu_a        (a),
        .mas_alu_b        (b),
        .mas_alu_c        (c),
        .mas_alu_ready    (ready),
        .mas_alu_busy     (busy),
        .mas_alu_result   (result),
        .mas_alu_zero     (zero),
        .mas_alu_neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_result(input logic [1:0] o, input int unsigned x,
                                                    input int unsigned y, input int unsigned z);
        int unsigned r;
        case (o)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = x * y + z;
        endcase
        return r[2*W-1:0];
    endfunction

    // Cycles from the start edge until ready is first seen high.
    function automatic int model_latency(input logic [1:0] o, input int unsigned y);
        int bits;
        if (o < 2) return 2;
`ifdef MAS_ALU_EXEC_EARLY_TERM_EN
        bits = 0;
        for (int i = 0; i < 32; i++) if ((y >> i) != 0) bits = i + 1;
        if (bits == 0) bits = 1;
        return bits + 1;
`else
        bits = y;
        return W + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input int hold);
        logic [2*W-1:0] er;
        logic           ez, en;
        int             lat;
        er  = model_result(o, x, y, z);
        ez  = (er == '0);
        en  = (o == 2'd1) && (x < y);
        lat = model_latency(o, y);
        op = o; a = x; b = y; c = z; oper = 1'b1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            tick();
            if (cyc == 1) begin
                op = 2'($urandom); a = W'($urandom); b = W'($urandom); c = W'($urandom);
            end
            checks++;
            if (busy !== (cyc < lat)) begin
                errors++;
                $display("FAIL busy op=%0d a=%h b=%h cyc=%0d: got %b expected %b", o, x, y, cyc, busy, cyc < lat);
            end
            checks++;
            if (ready !== (cyc == lat)) begin
                errors++;
                $display("FAIL ready op=%0d a=%h b=%h cyc=%0d: got %b expected %b", o, x, y, cyc, ready, cyc == lat);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                tick();
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_ready h=%0d: got %b expected 1", h, ready);
                end
            end
            checks++;
            if (result !== er || zero !== ez || neg !== en) begin
                errors++;
                $display("FAIL result op=%0d a=%h b=%h c=%h h=%0d: got %h z=%b n=%b expected %h z=%b n=%b",
                         o, x, y, z, h, result, zero, neg, er, ez, en);
            end
        end
        oper = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== er) begin
            errors++;
            $display("FAIL release: got ready=%b busy=%b result=%h expected 0 0 %h", ready, busy, result, er);
        end
        last_result = er; last_zero = ez; last_neg = en;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; oper = 1'b0; op = '0; a = '0; b = '0; c = '0;
        tick(); tick();
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== '0 || zero !== 1'b0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %b %h %b %b expected all 0", ready, busy, result, zero, neg);
        end
        // Strobe high across reset release must not start anything.
        oper = 1'b1; op = 2'd0; a = 8'h12; b = 8'h34;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || ready !== 1'b0) begin
                errors++;
                $display("FAIL strobe_after_reset cyc=%0d: got busy=%b ready=%b expected 0 0", i, busy, ready);
            end
        end
        oper = 1'b0;
        tick();
        last_result = '0; last_zero = 1'b0; last_neg = 1'b0;
    endtask

    task automatic test_directed();
        run_op(2'd0, 8'hFF, 8'h01, 8'h00, 0);
        run_op(2'd1, 8'h03, 8'h05, 8'h00, 0);
        run_op(2'd1, 8'h05, 8'h05, 8'h00, 0);
        run_op(2'd2, 8'hFF, 8'hFF, 8'h00, 0);
        run_op(2'd3, 8'hFF, 8'hFF, 8'hFF, 0);
        run_op(2'd2, 8'h07, 8'h04, 8'h00, 0);
        run_op(2'd2, 8'h9A, 8'h00, 8'h00, 0);
        run_op(2'd3, 8'h00, 8'h01, 8'h00, 0);
    endtask

    task automatic test_hold();
        run_op(2'd0, 8'h40, 8'h22, 8'h00, 5);
        run_op(2'd3, 8'h11, 8'h83, 8'h07, 5);
    endtask

    task automatic test_abort();
        oper = 1'b1; op = 2'd2; a = 8'h5A; b = 8'h80 | W'($urandom); c = 8'h00;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 4) oper = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0 || result !== last_result || zero !== last_zero || neg !== last_neg) begin
                errors++;
                $display("FAIL abort cyc=%0d: got ready=%b busy=%b result=%h expected 0 0 %h",
                         i, ready, busy, result, last_result);
            end
        end
    endtask

    task automatic test_reset_mid();
        oper = 1'b1; op = 2'd3; a = 8'hC3; b = 8'hF1; c = 8'h10;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== '0 || zero !== 1'b0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_calc: got %b %b %h %b %b expected all 0", ready, busy, result, zero, neg);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart: got busy=%b ready=%b expected 0 0", busy, ready);
        end
        oper = 1'b0;
        tick();
        last_result = '0; last_zero = 1'b0; last_neg = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), W'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), W'($urandom), W'($urandom), W'($urandom), 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
